// File: rtl/obf_pkg.sv
// ---------------------------------------------------------------------------
// obf_pkg
// Shared definitions for the obfuscation key path.
//   - OBF_KEY_WIDTH : default number of key bits. The obfuscation mux bank
//                     sizes its key port from this same constant.
//   - OBF_TIMEOUT   : default number of idle cycles allowed between accepted
//                     serial bits before a load is abandoned.
//   - loaderState_t : state encoding of the key loader FSM.
// ---------------------------------------------------------------------------
package obf_pkg;

   localparam int OBF_KEY_WIDTH = 16;
   localparam int OBF_TIMEOUT   = 255;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } loaderState_t;

endpackage

// File: rtl/obf_key_shifter.sv
// ---------------------------------------------------------------------------
// obf_key_shifter
// Shadow register for an incoming key. Serial bits arrive LSB first and are
// written into the shadow at the position given by an internal bit counter.
// An XOR of every accepted bit is kept alongside, so the parity check at the
// end of the frame needs no wide reduction tree.
//
// Ports
//   Clk      in   system clock, rising edge
//   Rst      in   synchronous active-high reset
//   init     in   clears shadow, bit counter and running parity
//   shiftEn  in   accept bitIn into the current bit position
//   bitIn    in   serial key bit
//   shadow   out  partially/fully shifted key (never seen by the bank)
//   parity   out  XOR of all bits accepted since init
//   lastBit  out  the bit counter points at the final key position
// ---------------------------------------------------------------------------
module obf_key_shifter
   import obf_pkg::*;
#(
   parameter int KEY_WIDTH = OBF_KEY_WIDTH
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 init,
   input  logic                 shiftEn,
   input  logic                 bitIn,
   output logic [KEY_WIDTH-1:0] shadow,
   output logic                 parity,
   output logic                 lastBit
);

   localparam int CW = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;

   logic [CW-1:0] bitCnt;

   // The counter tells the FSM when the frame's data bits are complete.
   assign lastBit = (bitCnt == CW'(KEY_WIDTH - 1));

   // Shadow, bit counter and running parity move together on every accepted
   // bit. The counter holds at the last position instead of wrapping; the
   // FSM has already moved on to the parity bit by then.
   always_ff @(posedge Clk) begin
      if (Rst || init) begin
         shadow <= '0;
         bitCnt <= '0;
         parity <= 1'b0;
      end else if (shiftEn) begin
         shadow[bitCnt] <= bitIn;
         parity         <= parity ^ bitIn;
         if (!lastBit) begin
            bitCnt <= bitCnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/obf_key_loader.sv
// ---------------------------------------------------------------------------
// obf_key_loader
// Serial key-activation controller feeding the obfuscation mux bank. A key is
// shifted in LSB first, followed by one even-parity bit. A good frame is
// committed to Key in one step and GKey is raised; a bad parity bit or an
// idle timeout leaves Key untouched and drops GKey. Clear relocks the bank.
//
// Ports
//   Clk       in   system clock, rising edge
//   Rst       in   synchronous active-high reset
//   Start     in   begin a key load (only honoured when idle)
//   Clear     in   relock: abort any load, zero Key, drop GKey
//   SerIn     in   serial key data, LSB first, then parity bit
//   SerValid  in   SerIn is sampled on cycles where this is high
//   Busy      out  a load is in progress
//   Done      out  one-cycle pulse, key committed
//   Error     out  one-cycle pulse, parity failure or timeout
//   Key       out  committed key to the obfuscation bank
//   GKey      out  global key enable, high only after a successful commit
// ---------------------------------------------------------------------------
module obf_key_loader
   import obf_pkg::*;
#(
   parameter int KEY_WIDTH = OBF_KEY_WIDTH,
   parameter int TIMEOUT   = OBF_TIMEOUT
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 Start,
   input  logic                 Clear,
   input  logic                 SerIn,
   input  logic                 SerValid,
   output logic                 Busy,
   output logic                 Done,
   output logic                 Error,
   output logic [KEY_WIDTH-1:0] Key,
   output logic                 GKey
);

   localparam int TW = $clog2(TIMEOUT + 1);

   loaderState_t         state;
   logic [TW-1:0]        idleCnt;
   logic [KEY_WIDTH-1:0] shadow;
   logic                 runParity;
   logic                 lastBit;
   logic                 shifterInit;
   logic                 shiftEn;
   logic                 idleExpired;
   logic                 parityGood;

   // Control strobes for the shifter plus the two decisions the FSM makes.
   // The idle counter counts completed idle cycles, so when it already holds
   // TIMEOUT-1 the current idle cycle is the TIMEOUT-th one and the load
   // aborts on this edge. Clear also wipes the shadow so a relocked part
   // keeps no trace of a half-loaded key.
   always_comb begin
      shifterInit = Clear || ((state == ST_IDLE) && Start);
      shiftEn     = !Clear && (state == ST_SHIFT) && SerValid;
      idleExpired = (idleCnt == TW'(TIMEOUT - 1));
      parityGood  = !(runParity ^ SerIn);
   end

   obf_key_shifter #(
      .KEY_WIDTH (KEY_WIDTH)
   ) shifter (
      .Clk     (Clk),
      .Rst     (Rst),
      .init    (shifterInit),
      .shiftEn (shiftEn),
      .bitIn   (SerIn),
      .shadow  (shadow),
      .parity  (runParity),
      .lastBit (lastBit)
   );

   // Main FSM with the idle counter and the committed key registers. Clear
   // is checked before anything else so it wins over Start, SerValid and a
   // commit landing in the same cycle, and it never produces Done/Error.
   // Key is only ever loaded from a complete shadow on a good parity bit,
   // so the bank never sees a partial key.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state   <= ST_IDLE;
         idleCnt <= '0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
         Error   <= 1'b0;
         Key     <= '0;
         GKey    <= 1'b0;
      end else begin
         Done  <= 1'b0;
         Error <= 1'b0;
         if (Clear) begin
            state   <= ST_IDLE;
            idleCnt <= '0;
            Busy    <= 1'b0;
            Key     <= '0;
            GKey    <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (Start) begin
                     state   <= ST_SHIFT;
                     Busy    <= 1'b1;
                     idleCnt <= '0;
                  end
               end
               ST_SHIFT, ST_PARITY: begin
                  if (SerValid) begin
                     idleCnt <= '0;
                     if (state == ST_SHIFT) begin
                        if (lastBit) begin
                           state <= ST_PARITY;
                        end
                     end else begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                        if (parityGood) begin
                           Key  <= shadow;
                           GKey <= 1'b1;
                           Done <= 1'b1;
                        end else begin
                           GKey  <= 1'b0;
                           Error <= 1'b1;
                        end
                     end
                  end else if (idleExpired) begin
                     state   <= ST_IDLE;
                     idleCnt <= '0;
                     Busy    <= 1'b0;
                     GKey    <= 1'b0;
                     Error   <= 1'b1;
                  end else begin
                     idleCnt <= idleCnt + TW'(1);
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  Busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_obf_key_loader.sv
// ---------------------------------------------------------------------------
// tb_obf_key_loader
// Directed bench for obf_key_loader with KEY_WIDTH=8, TIMEOUT=4. The stimulus
// side pushes the expected Done/Error event into a scoreboard queue before
// driving a frame; a monitor on the falling edge pops and compares whenever
// the DUT pulses Done or Error. Any pulse with nothing expected is a failure.
// ---------------------------------------------------------------------------
module tb_obf_key_loader;

   localparam int KW = 8;
   localparam int TO = 4;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          Start;
   logic          Clear;
   logic          SerIn;
   logic          SerValid;
   logic          Busy;
   logic          Done;
   logic          Error;
   logic [KW-1:0] Key;
   logic          GKey;

   int checks     = 0;
   int failures   = 0;
   int edgeCount  = 0;
   int eventCount = 0;
   int startEdge  = 0;
   int evBefore;

   typedef struct {
      bit            isDone;
      logic [KW-1:0] key;
      bit            gkey;
      bit            chkLat;
      int            lat;
   } expect_t;

   expect_t sb[$];

   obf_key_loader #(
      .KEY_WIDTH (KW),
      .TIMEOUT   (TO)
   ) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Start    (Start),
      .Clear    (Clear),
      .SerIn    (SerIn),
      .SerValid (SerValid),
      .Busy     (Busy),
      .Done     (Done),
      .Error    (Error),
      .Key      (Key),
      .GKey     (GKey)
   );

   // Free-running clock.
   always #5 Clk = ~Clk;

   // Edge counter used to measure Start-to-Done latency.
   always @(posedge Clk) edgeCount <= edgeCount + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic pushExpect(input bit isDone, input logic [KW-1:0] key,
                             input bit gkey, input bit chkLat, input int lat);
      expect_t e;
      e.isDone = isDone;
      e.key    = key;
      e.gkey   = gkey;
      e.chkLat = chkLat;
      e.lat    = lat;
      sb.push_back(e);
   endtask

   task automatic pulseStart();
      Start = 1'b1;
      stepCycle();
      Start     = 1'b0;
      startEdge = edgeCount;
   endtask

   task automatic sendBit(input logic b);
      SerIn    = b;
      SerValid = 1'b1;
      stepCycle();
      SerValid = 1'b0;
      SerIn    = 1'b0;
   endtask

   // One frame: Start, KW data bits LSB first, parity bit. An optional idle
   // gap follows data bit gapAfter, optionally with Start held high, and
   // Clear can be raised in the same cycle as the parity bit.
   task automatic applyStimulus(input logic [KW-1:0] key, input logic parityBit,
                                input int gapAfter, input int gapLen,
                                input bit clearOnParity, input bit restartInGap);
      pulseStart();
      for (int i = 0; i < KW; i++) begin
         sendBit(key[i]);
         if (i == gapAfter) begin
            Start = restartInGap;
            repeat (gapLen) stepCycle();
            Start = 1'b0;
         end
      end
      Clear = clearOnParity;
      sendBit(parityBit);
      Clear = 1'b0;
   endtask

   // Bounded wait for the monitor to consume every expected event.
   task automatic waitScoreboard();
      for (int i = 0; i < 20 && sb.size() != 0; i++) stepCycle();
      checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   // Monitor: compares each Done/Error pulse with the oldest expectation.
   // The latency is the edge at which a downstream register captures Done,
   // counted from the edge that sampled Start.
   always @(negedge Clk) begin : monitor
      expect_t e;
      if (!Rst && (Done || Error)) begin
         eventCount++;
         if (sb.size() == 0) begin
            checkOutput("unexpected_event", {30'd0, Done, Error}, 32'd0);
         end else begin
            e = sb.pop_front();
            checkOutput("evt_done", 32'(Done), 32'(e.isDone));
            checkOutput("evt_error", 32'(Error), 32'(!e.isDone));
            checkOutput("evt_key", 32'(Key), 32'(e.key));
            checkOutput("evt_gkey", 32'(GKey), 32'(e.gkey));
            checkOutput("evt_busy", 32'(Busy), 32'd0);
            if (e.chkLat) begin
               checkOutput("evt_latency", 32'(edgeCount + 1 - startEdge), 32'(e.lat));
            end
         end
      end
   end

   initial begin
      Rst      = 1'b1;
      Start    = 1'b0;
      Clear    = 1'b0;
      SerIn    = 1'b0;
      SerValid = 1'b0;
      repeat (2) stepCycle();
      checkOutput("rst_key", 32'(Key), 32'd0);
      checkOutput("rst_gkey", 32'(GKey), 32'd0);
      checkOutput("rst_busy", 32'(Busy), 32'd0);
      checkOutput("rst_done", 32'(Done), 32'd0);
      checkOutput("rst_error", 32'(Error), 32'd0);
      Rst = 1'b0;
      stepCycle();

      $display("[TB] good load 8'hA5");
      pushExpect(1'b1, 8'hA5, 1'b1, 1'b1, 10);
      applyStimulus(8'hA5, 1'b0, -1, 0, 1'b0, 1'b0);
      waitScoreboard();
      checkOutput("good_key", 32'(Key), 32'hA5);
      checkOutput("good_gkey", 32'(GKey), 32'd1);

      $display("[TB] bad parity on 8'h3C");
      pushExpect(1'b0, 8'hA5, 1'b0, 1'b0, 0);
      applyStimulus(8'h3C, 1'b1, -1, 0, 1'b0, 1'b0);
      waitScoreboard();
      checkOutput("badpar_key", 32'(Key), 32'hA5);
      checkOutput("badpar_gkey", 32'(GKey), 32'd0);

      $display("[TB] timeout after 3 bits and 4 idle cycles");
      pulseStart();
      sendBit(1'b1);
      sendBit(1'b0);
      sendBit(1'b1);
      pushExpect(1'b0, 8'hA5, 1'b0, 1'b0, 0);
      repeat (TO) stepCycle();
      waitScoreboard();
      checkOutput("tmo_busy", 32'(Busy), 32'd0);
      checkOutput("tmo_key", 32'(Key), 32'hA5);
      checkOutput("tmo_gkey", 32'(GKey), 32'd0);

      $display("[TB] 3-cycle gap does not time out");
      pushExpect(1'b1, 8'hA5, 1'b1, 1'b0, 0);
      applyStimulus(8'hA5, 1'b0, 2, TO - 1, 1'b0, 1'b0);
      waitScoreboard();
      checkOutput("gap_key", 32'(Key), 32'hA5);
      checkOutput("gap_gkey", 32'(GKey), 32'd1);

      $display("[TB] Clear mid-shift beats Start and SerValid");
      evBefore = eventCount;
      pulseStart();
      sendBit(1'b1);
      sendBit(1'b0);
      sendBit(1'b1);
      Clear    = 1'b1;
      Start    = 1'b1;
      SerValid = 1'b1;
      SerIn    = 1'b1;
      stepCycle();
      Clear    = 1'b0;
      Start    = 1'b0;
      checkOutput("clr_busy", 32'(Busy), 32'd0);
      checkOutput("clr_key", 32'(Key), 32'd0);
      checkOutput("clr_gkey", 32'(GKey), 32'd0);
      repeat (3) stepCycle();
      SerValid = 1'b0;
      SerIn    = 1'b0;
      checkOutput("clr_idle_busy", 32'(Busy), 32'd0);
      checkOutput("clr_noevent", 32'(eventCount), 32'(evBefore));

      $display("[TB] Clear on parity cycle of a valid frame");
      pushExpect(1'b1, 8'hA5, 1'b1, 1'b1, 10);
      applyStimulus(8'hA5, 1'b0, -1, 0, 1'b0, 1'b0);
      waitScoreboard();
      checkOutput("pre_clr_key", 32'(Key), 32'hA5);
      evBefore = eventCount;
      applyStimulus(8'h3C, 1'b0, -1, 0, 1'b1, 1'b0);
      repeat (2) stepCycle();
      checkOutput("clrpar_key", 32'(Key), 32'd0);
      checkOutput("clrpar_gkey", 32'(GKey), 32'd0);
      checkOutput("clrpar_busy", 32'(Busy), 32'd0);
      checkOutput("clrpar_noevent", 32'(eventCount), 32'(evBefore));

      $display("[TB] Start while busy is ignored");
      pushExpect(1'b1, 8'hA5, 1'b1, 1'b0, 0);
      applyStimulus(8'hA5, 1'b0, 3, 1, 1'b0, 1'b1);
      waitScoreboard();
      checkOutput("rs_key", 32'(Key), 32'hA5);
      checkOutput("rs_gkey", 32'(GKey), 32'd1);

      $display("[TB] reset mid-load then load 8'h5A");
      pulseStart();
      for (int i = 0; i < 5; i++) sendBit(1'b1);
      Rst = 1'b1;
      stepCycle();
      Rst = 1'b0;
      checkOutput("mrst_key", 32'(Key), 32'd0);
      checkOutput("mrst_gkey", 32'(GKey), 32'd0);
      checkOutput("mrst_busy", 32'(Busy), 32'd0);
      checkOutput("mrst_done", 32'(Done), 32'd0);
      checkOutput("mrst_error", 32'(Error), 32'd0);
      pushExpect(1'b1, 8'h5A, 1'b1, 1'b1, 10);
      applyStimulus(8'h5A, 1'b0, -1, 0, 1'b0, 1'b0);
      waitScoreboard();
      checkOutput("post_key", 32'(Key), 32'h5A);
      checkOutput("post_gkey", 32'(GKey), 32'd1);

      repeat (2) stepCycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
